// File: rtl/mips_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// The sequencer uses the master side; the datapath (or a bench) uses the slave side.
interface mips_ctrl_if;
    logic [31:0] Instruction;
    logic        mem_stall;
    logic        RegDst;
    logic        RegWr;
    logic [1:0]  ExtOp;
    logic [1:0]  nPC_sel;
    logic [3:0]  ALUctr;
    logic        MemtoReg;
    logic        MemWr;
    logic        ALUSrc;
    logic        j_sel;
    logic [1:0]  move;
    logic        pc_wr;
    logic        halted;
    logic [31:0] instr_count;

    modport master (
        input  Instruction, mem_stall,
        output RegDst, RegWr, ExtOp, nPC_sel, ALUctr, MemtoReg, MemWr,
               ALUSrc, j_sel, move, pc_wr, halted, instr_count
    );

    modport slave (
        output Instruction, mem_stall,
        input  RegDst, RegWr, ExtOp, nPC_sel, ALUctr, MemtoReg, MemWr,
               ALUSrc, j_sel, move, pc_wr, halted, instr_count
    );
endinterface

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: latches the instruction, decodes it and
// drives datapath controls phase by phase, with memory stall, illegal-op halt and retire counter.
//
//   state  | meaning
//   FETCH  | latch Instruction into ir, all outputs 0
//   DECODE | classify ir; illegal goes to HALT
//   EXEC   | ALU phase; branches/jumps retire here
//   MEM    | data memory access, held while mem_stall
//   WB     | register write, retire
//   HALT   | illegal opcode trapped, left only by rst
module mips_ctrl_fsm (
    input  logic       clk,
    input  logic       rst,
    mips_ctrl_if.master bus
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [1:0] C_ALU   = 2'd0;
    localparam logic [1:0] C_LOAD  = 2'd1;
    localparam logic [1:0] C_STORE = 2'd2;
    localparam logic [1:0] C_BR    = 2'd3;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;

    logic [2:0]  state, state_nx;
    logic [31:0] ir;
    logic [31:0] count;
    logic [5:0]  op, funct;

    logic        legal;
    logic [1:0]  cls;
    logic        d_regdst, d_memtoreg, d_alusrc, d_jsel;
    logic [1:0]  d_extop, d_npc, d_move;
    logic [3:0]  d_alu;

    logic        active;
    logic        pc_wr_i;
    logic        unused_ir_bits;

    assign op             = ir[31:26];
    assign funct          = ir[5:0];
    assign unused_ir_bits = ^ir[25:6];

    always_comb begin
        legal      = 1'b0;
        cls        = C_ALU;
        d_regdst   = 1'b0;
        d_memtoreg = 1'b0;
        d_alusrc   = 1'b0;
        d_jsel     = 1'b0;
        d_extop    = 2'b00;
        d_npc      = 2'b00;
        d_move     = 2'b00;
        d_alu      = ALU_ADD;
        case (op)
            6'b000000: begin
                d_regdst = 1'b1;
                legal    = 1'b1;
                case (funct)
                    6'b100001: d_alu = ALU_ADD;
                    6'b100011: d_alu = ALU_SUB;
                    6'b100100: d_alu = ALU_AND;
                    6'b100101: d_alu = ALU_OR;
                    6'b101010: d_alu = ALU_SLT;
                    6'b000000: begin
                        d_alu  = ALU_SLL;
                        d_move = 2'b01;
                    end
                    default:   legal = 1'b0;
                endcase
            end
            6'b001101: begin
                legal = 1'b1; d_alu = ALU_OR;  d_extop = 2'b00; d_alusrc = 1'b1;
            end
            6'b001001: begin
                legal = 1'b1; d_alu = ALU_ADD; d_extop = 2'b01; d_alusrc = 1'b1;
            end
            6'b001111: begin
                legal = 1'b1; d_alu = ALU_OR;  d_extop = 2'b10; d_alusrc = 1'b1;
            end
            6'b100011: begin
                legal = 1'b1; cls = C_LOAD;  d_alu = ALU_ADD; d_extop = 2'b01;
                d_alusrc = 1'b1; d_memtoreg = 1'b1;
            end
            6'b101011: begin
                legal = 1'b1; cls = C_STORE; d_alu = ALU_ADD; d_extop = 2'b01;
                d_alusrc = 1'b1;
            end
            6'b000100: begin
                legal = 1'b1; cls = C_BR; d_alu = ALU_SUB; d_npc = 2'b01;
            end
            6'b000101: begin
                legal = 1'b1; cls = C_BR; d_alu = ALU_SUB; d_npc = 2'b10;
            end
            6'b000010: begin
                legal = 1'b1; cls = C_BR; d_jsel = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: state_nx = legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                case (cls)
                    C_LOAD, C_STORE: state_nx = S_MEM;
                    C_BR:            state_nx = S_FETCH;
                    default:         state_nx = S_WB;
                endcase
            end
            S_MEM: begin
                if (!bus.mem_stall)
                    state_nx = (cls == C_STORE) ? S_FETCH : S_WB;
            end
            S_WB:     state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            ir    <= 32'd0;
            count <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == S_FETCH)
                ir <= bus.Instruction;
            if (pc_wr_i)
                count <= count + 32'd1;
        end
    end

    // Decoded controls are held from DECODE until the instruction retires;
    // everything is gated off while rst is high so a reset never commits a write.
    assign active = !rst && (state == S_DECODE || state == S_EXEC ||
                             state == S_MEM    || state == S_WB);

    assign pc_wr_i = !rst && ((state == S_WB) ||
                              (state == S_EXEC && cls == C_BR) ||
                              (state == S_MEM && cls == C_STORE && !bus.mem_stall));

    assign bus.RegDst      = active & d_regdst;
    assign bus.ExtOp       = active ? d_extop : 2'b00;
    assign bus.nPC_sel     = active ? d_npc   : 2'b00;
    assign bus.ALUctr      = active ? d_alu   : 4'b0000;
    assign bus.MemtoReg    = active & d_memtoreg;
    assign bus.ALUSrc      = active & d_alusrc;
    assign bus.j_sel       = active & d_jsel;
    assign bus.move        = active ? d_move  : 2'b00;
    assign bus.RegWr       = !rst && (state == S_WB);
    assign bus.MemWr       = !rst && (state == S_MEM) && (cls == C_STORE);
    assign bus.pc_wr       = pc_wr_i;
    assign bus.halted      = !rst && (state == S_HALT);
    assign bus.instr_count = count;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed bench for mips_ctrl_fsm: table of single instructions plus
// hand sequences for halt and mid-instruction reset.
module tb_mips_ctrl_fsm;

    logic clk;
    logic rst;
    mips_ctrl_if bus ();

    mips_ctrl_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl = {RegDst,RegWr,ExtOp,nPC_sel,ALUctr,MemtoReg,MemWr,ALUSrc,j_sel,move}
    typedef struct {
        logic [31:0] instr;
        int          nstall;
        int          exp_cyc;
        logic [15:0] exp_ctrl;
        int          exp_regwr;
        int          exp_memwr;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_count;

    function automatic logic [15:0] ctrl_now();
        return {bus.RegDst, bus.RegWr, bus.ExtOp, bus.nPC_sel, bus.ALUctr,
                bus.MemtoReg, bus.MemWr, bus.ALUSrc, bus.j_sel, bus.move};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.Instruction = 32'd0;
        bus.mem_stall   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_ctrl", {16'd0, ctrl_now()}, 32'd0);
        chk("reset_pcwr_halt", {30'd0, bus.pc_wr, bus.halted}, 32'd0);
        chk("reset_count", bus.instr_count, 32'd0);
        rst = 1'b0;
        exp_count = 32'd0;
    endtask

    // Entered at posedge+1 of the FETCH cycle; leaves at posedge+1 of the next FETCH.
    task automatic run_instr(input logic [31:0] instr, input int nstall,
                             output int cyc, output logic [15:0] ctrl,
                             output int nrw, output int nmw, output logic [15:0] fetch_ctrl);
        cyc = 0; ctrl = 16'd0; nrw = 0; nmw = 0; fetch_ctrl = 16'hFFFF;
        bus.Instruction = instr;
        for (int c = 1; c <= 20; c++) begin
            bus.mem_stall = (c >= 4 && c <= 3 + nstall);
            #1;
            if (c == 1) fetch_ctrl = ctrl_now() | {15'd0, bus.pc_wr};
            if (bus.RegWr) nrw++;
            if (bus.MemWr) nmw++;
            if (bus.pc_wr && cyc == 0) begin
                cyc  = c;
                ctrl = ctrl_now();
            end
            @(posedge clk);
            #1;
            if (cyc != 0) break;
        end
        bus.mem_stall = 1'b0;
    endtask

    task automatic halt_seq(input logic [31:0] instr);
        bus.Instruction = instr;
        for (int c = 1; c <= 8; c++) begin
            #1;
            chk($sformatf("halt_flag_c%0d", c), {31'd0, bus.halted}, {31'd0, (c >= 3)});
            chk($sformatf("halt_strobes_c%0d", c),
                {29'd0, bus.RegWr, bus.MemWr, bus.pc_wr}, 32'd0);
            if (c >= 3) chk($sformatf("halt_ctrl_c%0d", c), {16'd0, ctrl_now()}, 32'd0);
            @(posedge clk);
            #1;
        end
        chk("halt_count", bus.instr_count, exp_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, nrw, nmw;
        logic [15:0] ctrl, fctrl;

        vecs[0]  = '{32'h00000000, 0, 4, 16'b1_1_00_00_0101_0_0_0_0_01, 1, 0}; // sll nop
        vecs[1]  = '{32'h00221821, 0, 4, 16'b1_1_00_00_0000_0_0_0_0_00, 1, 0}; // addu
        vecs[2]  = '{32'h34430005, 0, 4, 16'b0_1_00_00_0011_0_0_1_0_00, 1, 0}; // ori
        vecs[3]  = '{32'h8C430004, 2, 7, 16'b0_1_01_00_0000_1_0_1_0_00, 1, 0}; // lw, 2 stalls
        vecs[4]  = '{32'hAC430004, 1, 5, 16'b0_0_01_00_0000_0_1_1_0_00, 0, 2}; // sw, 1 stall
        vecs[5]  = '{32'h10220003, 0, 3, 16'b0_0_00_01_0001_0_0_0_0_00, 0, 0}; // beq
        vecs[6]  = '{32'h08000010, 0, 3, 16'b0_0_00_00_0000_0_0_0_1_00, 0, 0}; // j
        vecs[7]  = '{32'h00221823, 0, 4, 16'b1_1_00_00_0001_0_0_0_0_00, 1, 0}; // subu
        vecs[8]  = '{32'h00221824, 0, 4, 16'b1_1_00_00_0010_0_0_0_0_00, 1, 0}; // and
        vecs[9]  = '{32'h00221825, 0, 4, 16'b1_1_00_00_0011_0_0_0_0_00, 1, 0}; // or
        vecs[10] = '{32'h0022182A, 0, 4, 16'b1_1_00_00_0100_0_0_0_0_00, 1, 0}; // slt
        vecs[11] = '{32'h24430005, 0, 4, 16'b0_1_01_00_0000_0_0_1_0_00, 1, 0}; // addiu
        vecs[12] = '{32'h3C031234, 0, 4, 16'b0_1_10_00_0011_0_0_1_0_00, 1, 0}; // lui
        vecs[13] = '{32'h14220003, 0, 3, 16'b0_0_00_10_0001_0_0_0_0_00, 0, 0}; // bne
        vecs[14] = '{32'hAC430004, 0, 4, 16'b0_0_01_00_0000_0_1_1_0_00, 0, 1}; // sw, no stall
        vecs[15] = '{32'h8C430004, 0, 5, 16'b0_1_01_00_0000_1_0_1_0_00, 1, 0}; // lw, no stall
        vecs[16] = '{32'h00221821, 2, 4, 16'b1_1_00_00_0000_0_0_0_0_00, 1, 0}; // stall outside MEM ignored

        do_reset();

        for (int i = 0; i < NV; i++) begin
            run_instr(vecs[i].instr, vecs[i].nstall, cyc, ctrl, nrw, nmw, fctrl);
            exp_count = exp_count + 32'd1;
            chk($sformatf("v%0d_pcwr_cycle", i), cyc, vecs[i].exp_cyc);
            chk($sformatf("v%0d_ctrl", i), {16'd0, ctrl}, {16'd0, vecs[i].exp_ctrl});
            chk($sformatf("v%0d_regwr_cycles", i), nrw, vecs[i].exp_regwr);
            chk($sformatf("v%0d_memwr_cycles", i), nmw, vecs[i].exp_memwr);
            chk($sformatf("v%0d_fetch_zero", i), {16'd0, fctrl}, 32'd0);
            chk($sformatf("v%0d_count", i), bus.instr_count, exp_count);
        end

        halt_seq(32'hFC000000);
        do_reset();
        halt_seq(32'h00000001);
        do_reset();

        // rst during EXEC of addu, then the next instruction must start from FETCH
        bus.Instruction = 32'h00221821;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("rst_exec_strobes", {29'd0, bus.RegWr, bus.MemWr, bus.pc_wr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_instr(32'h00221821, 0, cyc, ctrl, nrw, nmw, fctrl);
        exp_count = exp_count + 32'd1;
        chk("rst_exec_restart_cycle", cyc, 4);
        chk("rst_exec_restart_count", bus.instr_count, exp_count);

        // rst during WB must suppress the register write and the retire
        bus.Instruction = 32'h34430005;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("rst_wb_strobes", {29'd0, bus.RegWr, bus.MemWr, bus.pc_wr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_count = 32'd0;
        chk("rst_wb_count", bus.instr_count, exp_count);
        run_instr(32'h34430005, 0, cyc, ctrl, nrw, nmw, fctrl);
        exp_count = exp_count + 32'd1;
        chk("rst_wb_restart_cycle", cyc, 4);
        chk("rst_wb_restart_ctrl", {16'd0, ctrl}, {16'd0, 16'b0_1_00_00_0011_0_0_1_0_00});
        chk("rst_wb_restart_count", bus.instr_count, exp_count);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
